// File: rtl/button_event_arbiter.sv
// Button front end: per-channel two-flop sync, counter debounce, rising-edge capture into
// one pending flag per channel, and round-robin hand-off into a single valid/ready slot.
module button_event_arbiter #(
  parameter int unsigned N               = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 ena_i,
  input  logic [N-1:0]         buttons_i,
  output logic                 event_valid_o,
  input  logic                 event_ready_i,
  output logic [$clog2(N)-1:0] event_id_o,
  output logic [N-1:0]         event_pending_o,
  output logic                 overflow_o
);

  localparam int unsigned IdW    = $clog2(N);
  localparam int unsigned CntW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [IdW-1:0]  PtrRst = IdW'(N - 1);

  logic [N-1:0]    sync1_q, sync2_q;
  logic [N-1:0]    stable_q, stable_d;
  logic [CntW-1:0] cnt_q [N];
  logic [CntW-1:0] cnt_d [N];
  logic [N-1:0]    press;

  logic [N-1:0]    pending_q, pending_d;
  logic            valid_q, valid_d;
  logic [IdW-1:0]  id_q, id_d;
  logic [IdW-1:0]  ptr_q, ptr_d;
  logic            overflow_q, overflow_d;

  logic            any_pending;
  logic [IdW-1:0]  winner;
  logic            slot_free;
  logic            load;

  // Debounce: a differing level must persist DEBOUNCE_CYCLES edges; any return restarts it.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < int'(N); i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CntMax) begin
          stable_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
    press = stable_d & ~stable_q;
  end

  // Synchronizer, stable level and debounce counter state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      cnt_q    <= '{default: '0};
    end else begin
      sync1_q  <= buttons_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  // Round-robin search starting just after the last winner.
  always_comb begin
    int unsigned    idx;
    logic [IdW-1:0] idx_w;
    any_pending = 1'b0;
    winner      = '0;
    idx         = 0;
    idx_w       = '0;
    for (int unsigned off = 1; off <= N; off++) begin
      idx   = (32'(ptr_q) + off) % N;
      idx_w = idx[IdW-1:0];
      if (!any_pending && pending_q[idx_w]) begin
        any_pending = 1'b1;
        winner      = idx_w;
      end
    end
  end

  // Slot reload, pending set/clear (set wins) and sticky overflow.
  always_comb begin
    valid_d    = valid_q;
    id_d       = id_q;
    ptr_d      = ptr_q;
    pending_d  = pending_q;
    overflow_d = overflow_q;
    slot_free  = !valid_q || event_ready_i;
    load       = slot_free && any_pending;
    if (slot_free) begin
      if (any_pending) begin
        id_d              = winner;
        valid_d           = 1'b1;
        pending_d[winner] = 1'b0;
        ptr_d             = winner;
      end else begin
        valid_d = 1'b0;
      end
    end
    for (int i = 0; i < int'(N); i++) begin
      if (press[i] && ena_i) begin
        if (pending_q[i] && !(load && (winner == IdW'(i)))) begin
          overflow_d = 1'b1;
        end
        pending_d[i] = 1'b1;
      end
    end
  end

  // Arbiter and output slot state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending_q  <= '0;
      valid_q    <= 1'b0;
      id_q       <= '0;
      ptr_q      <= PtrRst;
      overflow_q <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      valid_q    <= valid_d;
      id_q       <= id_d;
      ptr_q      <= ptr_d;
      overflow_q <= overflow_d;
    end
  end

  assign event_valid_o   = valid_q;
  assign event_id_o      = id_q;
  assign event_pending_o = pending_q;
  assign overflow_o      = overflow_q;

endmodule

// File: tb/tb_button_event_arbiter.sv
// Directed bench for button_event_arbiter (N=4, DEBOUNCE_CYCLES=8).
module tb_button_event_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ena = 1'b1;
  logic [3:0] buttons = '0;
  logic       ready = 1'b0;
  logic       ev_valid;
  logic [1:0] ev_id;
  logic [3:0] ev_pending;
  logic       ovf;

  int errors = 0;
  int checks = 0;
  int ev_q[$];

  button_event_arbiter #(.N(4), .DEBOUNCE_CYCLES(8)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .ena_i           (ena),
    .buttons_i       (buttons),
    .event_valid_o   (ev_valid),
    .event_ready_i   (ready),
    .event_id_o      (ev_id),
    .event_pending_o (ev_pending),
    .overflow_o      (ovf)
  );

  always #5 clk = ~clk;

  // Inputs are stable at the negedge, so valid && ready here is a handshake at the next edge.
  always @(negedge clk) begin
    if (ev_valid && ready && !rst) ev_q.push_back(int'(ev_id));
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (ev_valid) begin
        ok = 1'b1;
        break;
      end
      step(1);
    end
  endtask

  task automatic test_reset();
    buttons = 4'b1111;
    ready   = 1'b0;
    rst     = 1'b1;
    step(2);
    checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", ev_valid); end
    checks++; if (ev_pending !== 4'b0000) begin errors++; $display("FAIL reset_pending: got %b want 0000", ev_pending); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", ovf); end
    buttons = 4'b0000;
    rst     = 1'b0;
    step(15);
    checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL reset_idle_valid: got %b want 0", ev_valid); end
  endtask

  task automatic test_single_press();
    ready = 1'b1;
    ev_q.delete();
    buttons[2] = 1'b1;
    for (int j = 0; j <= 12; j++) begin
      step(1);
      if (j == 9) begin
        checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL single_early: got %b want 0", ev_valid); end
        checks++; if (ev_pending !== 4'b0100) begin errors++; $display("FAIL single_pending: got %b want 0100", ev_pending); end
      end
      if (j == 10) begin
        checks++; if (ev_valid !== 1'b1 || ev_id !== 2'd2) begin errors++; $display("FAIL single_event: got valid=%b id=%0d want valid=1 id=2", ev_valid, ev_id); end
      end
      if (j == 11) begin
        checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL single_one_cycle: got %b want 0", ev_valid); end
      end
    end
    step(17);
    buttons[2] = 1'b0;
    step(20);
    checks++; if (ev_q.size() !== 1) begin errors++; $display("FAIL single_count: got %0d want 1", ev_q.size()); end
  endtask

  task automatic test_bounce();
    ready = 1'b1;
    ev_q.delete();
    for (int p = 0; p < 4; p++) begin
      buttons[1] = 1'b1;
      step(3);
      buttons[1] = 1'b0;
      step(3);
    end
    buttons[1] = 1'b1;
    for (int j = 0; j <= 12; j++) begin
      step(1);
      if (j == 9) begin
        checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL bounce_early: got %b want 0", ev_valid); end
      end
      if (j == 10) begin
        checks++; if (ev_valid !== 1'b1 || ev_id !== 2'd1) begin errors++; $display("FAIL bounce_event: got valid=%b id=%0d want valid=1 id=1", ev_valid, ev_id); end
      end
    end
    step(10);
    checks++; if (ev_q.size() !== 1) begin errors++; $display("FAIL bounce_count: got %0d want 1", ev_q.size()); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL bounce_overflow: got %b want 0", ovf); end
    buttons[1] = 1'b0;
    step(15);
  endtask

  task automatic test_round_robin();
    bit ok;
    do_reset();
    ready   = 1'b0;
    ev_q.delete();
    buttons = 4'b1011;
    wait_valid(40, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rr_timeout: got no valid want valid"); end
    checks++; if (ev_id !== 2'd0) begin errors++; $display("FAIL rr_first_id: got %0d want 0", ev_id); end
    checks++; if (ev_pending !== 4'b1010) begin errors++; $display("FAIL rr_pending: got %b want 1010", ev_pending); end
    for (int c = 0; c < 5; c++) begin
      step(1);
      checks++; if (ev_valid !== 1'b1 || ev_id !== 2'd0) begin errors++; $display("FAIL rr_stall: got valid=%b id=%0d want valid=1 id=0", ev_valid, ev_id); end
    end
    ready = 1'b1;
    step(5);
    checks++; if (ev_q.size() !== 3) begin errors++; $display("FAIL rr_count: got %0d want 3", ev_q.size()); end
    else begin
      checks++; if (ev_q[0] !== 0 || ev_q[1] !== 1 || ev_q[2] !== 3) begin errors++; $display("FAIL rr_order: got %0d,%0d,%0d want 0,1,3", ev_q[0], ev_q[1], ev_q[2]); end
    end
    buttons = 4'b0000;
    step(15);
    // Pointer now sits at 3, so channel 0 is searched first again.
    ready   = 1'b0;
    ev_q.delete();
    buttons = 4'b1001;
    wait_valid(40, ok);
    checks++; if (!ok || ev_id !== 2'd0) begin errors++; $display("FAIL rr2_first: got valid=%b id=%0d want valid=1 id=0", ev_valid, ev_id); end
    ready = 1'b1;
    step(4);
    checks++; if (ev_q.size() !== 2) begin errors++; $display("FAIL rr2_count: got %0d want 2", ev_q.size()); end
    else begin
      checks++; if (ev_q[0] !== 0 || ev_q[1] !== 3) begin errors++; $display("FAIL rr2_order: got %0d,%0d want 0,3", ev_q[0], ev_q[1]); end
    end
    buttons = 4'b0000;
    step(15);
  endtask

  task automatic test_overflow();
    do_reset();
    ready = 1'b0;
    ev_q.delete();
    for (int p = 0; p < 3; p++) begin
      buttons[1] = 1'b1;
      step(14);
      buttons[1] = 1'b0;
      step(14);
      if (p == 0) begin
        checks++; if (ev_valid !== 1'b1 || ev_id !== 2'd1 || ev_pending !== 4'b0000) begin errors++; $display("FAIL ovf_first: got valid=%b id=%0d pend=%b want 1,1,0000", ev_valid, ev_id, ev_pending); end
      end
      if (p == 1) begin
        checks++; if (ev_pending !== 4'b0010 || ovf !== 1'b0) begin errors++; $display("FAIL ovf_second: got pend=%b ovf=%b want 0010,0", ev_pending, ovf); end
      end
      if (p == 2) begin
        checks++; if (ev_pending !== 4'b0010 || ovf !== 1'b1) begin errors++; $display("FAIL ovf_third: got pend=%b ovf=%b want 0010,1", ev_pending, ovf); end
      end
    end
    ready = 1'b1;
    step(10);
    checks++; if (ev_q.size() !== 2) begin errors++; $display("FAIL ovf_count: got %0d want 2", ev_q.size()); end
    else begin
      checks++; if (ev_q[0] !== 1 || ev_q[1] !== 1) begin errors++; $display("FAIL ovf_ids: got %0d,%0d want 1,1", ev_q[0], ev_q[1]); end
    end
    checks++; if (ovf !== 1'b1 || ev_valid !== 1'b0) begin errors++; $display("FAIL ovf_sticky: got ovf=%b valid=%b want 1,0", ovf, ev_valid); end
  endtask

  task automatic test_ena_and_reset();
    bit ok;
    do_reset();
    ready = 1'b1;
    ena   = 1'b0;
    ev_q.delete();
    buttons[2] = 1'b1;
    step(14);
    checks++; if (ev_pending !== 4'b0000 || ev_valid !== 1'b0 || ovf !== 1'b0) begin errors++; $display("FAIL ena_off: got pend=%b valid=%b ovf=%b want 0000,0,0", ev_pending, ev_valid, ovf); end
    buttons[2] = 1'b0;
    step(14);
    checks++; if (ev_q.size() !== 0) begin errors++; $display("FAIL ena_off_count: got %0d want 0", ev_q.size()); end
    ena   = 1'b1;
    ready = 1'b0;
    buttons[3] = 1'b1;
    wait_valid(40, ok);
    checks++; if (!ok || ev_id !== 2'd3) begin errors++; $display("FAIL rst_pre: got valid=%b id=%0d want valid=1 id=3", ev_valid, ev_id); end
    rst     = 1'b1;
    buttons = 4'b0000;
    step(1);
    checks++; if (ev_valid !== 1'b0 || ev_pending !== 4'b0000) begin errors++; $display("FAIL rst_mid: got valid=%b pend=%b want 0,0000", ev_valid, ev_pending); end
    rst   = 1'b0;
    ready = 1'b1;
    ev_q.delete();
    step(20);
    checks++; if (ev_q.size() !== 0 || ev_valid !== 1'b0) begin errors++; $display("FAIL rst_stale: got count=%0d valid=%b want 0,0", ev_q.size(), ev_valid); end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_bounce();
    test_round_robin();
    test_overflow();
    test_ena_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
